// File: rtl/ddsm_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// ddsm_cfg_ctrl
//
// Configuration and sequencing controller for a cascaded EFM delta-sigma
// modulator. It accepts a width/seed/frac configuration, derives the
// sum-mask and one-hot carry-select words broadcast to every EFM stage,
// holds the datapath in reset for a flush period, then runs the
// pipeline through a warmup window before flagging valid output.
//
// Optional feature macro: DDSM_CFG_RANGE_CHECK_EN
//   defined   : requests with i_cfg_width > P_DATA_WIDTH are rejected and
//               o_cfg_err pulses for one cycle; nothing else changes.
//   undefined : such widths are clamped to P_DATA_WIDTH; o_cfg_err is 0.
//
// Ports
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_cfg_valid  configuration request
//   o_cfg_ready  controller accepts a configuration (IDLE / RUN)
//   i_cfg_width  requested effective EFM width (0 = bypass)
//   i_cfg_seed   accumulator seed
//   i_cfg_frac   fractional input word
//   i_run_en     run request
//   o_sum_sel    sum mask, 2^w - 1
//   o_cout_sel   one-hot carry select, 1 << w
//   o_seed       latched seed
//   o_frac       latched fractional word
//   o_dp_rst_n   datapath reset, active-low
//   o_dp_en      datapath clock-enable
//   o_out_valid  modulator output valid
//   o_state      current state encoding
//   o_cfg_err    one-cycle pulse on a rejected configuration
// ----------------------------------------------------------------------------
module ddsm_cfg_ctrl #(
    parameter int unsigned P_DATA_WIDTH   = 8,
    parameter int unsigned P_STAGES       = 3,
    parameter int unsigned P_FLUSH_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [3:0]              i_cfg_width,
    input  logic [P_DATA_WIDTH-1:0] i_cfg_seed,
    input  logic [P_DATA_WIDTH-1:0] i_cfg_frac,
    input  logic                    i_run_en,
    output logic [P_DATA_WIDTH-1:0] o_sum_sel,
    output logic [P_DATA_WIDTH:0]   o_cout_sel,
    output logic [P_DATA_WIDTH-1:0] o_seed,
    output logic [P_DATA_WIDTH-1:0] o_frac,
    output logic                    o_dp_rst_n,
    output logic                    o_dp_en,
    output logic                    o_out_valid,
    output logic [2:0]              o_state,
    output logic                    o_cfg_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_WARMUP = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    localparam int unsigned FLUSH_CW = (P_FLUSH_CYCLES > 1) ? $clog2(P_FLUSH_CYCLES) : 1;
    localparam int unsigned WARM_CW  = (P_STAGES > 0) ? $clog2(P_STAGES + 1) : 1;

    localparam logic [FLUSH_CW-1:0] FLUSH_LAST = FLUSH_CW'(P_FLUSH_CYCLES - 1);
    localparam logic [WARM_CW-1:0]  WARM_LAST  = WARM_CW'(P_STAGES);

    localparam logic [P_DATA_WIDTH:0] COUT_RST = {1'b1, {P_DATA_WIDTH{1'b0}}};

    logic [2:0]              state_q;
    logic [2:0]              state_nxt;
    logic [FLUSH_CW-1:0]     flush_cnt_q;
    logic [FLUSH_CW-1:0]     flush_cnt_nxt;
    logic [WARM_CW-1:0]      warm_cnt_q;
    logic [WARM_CW-1:0]      warm_cnt_nxt;

    logic                    cfg_hit;
    logic                    cfg_take;
    logic                    cfg_bad;
    logic                    w_over;
    logic [3:0]              eff_w;
    logic [P_DATA_WIDTH-1:0] sum_sel_nxt;
    logic [P_DATA_WIDTH:0]   cout_sel_nxt;

    // o_cfg_ready is registered and only ever high in IDLE/RUN, so it
    // doubles as the acceptance qualifier.
    assign cfg_hit = i_cfg_valid & o_cfg_ready;
    assign w_over  = 32'(i_cfg_width) > P_DATA_WIDTH;

`ifdef DDSM_CFG_RANGE_CHECK_EN
    assign cfg_bad  = cfg_hit & w_over;
    assign cfg_take = cfg_hit & ~w_over;
    assign eff_w    = i_cfg_width;
`else
    assign cfg_bad  = 1'b0;
    assign cfg_take = cfg_hit;
    assign eff_w    = w_over ? 4'(P_DATA_WIDTH) : i_cfg_width;
`endif

    // Width 0 naturally yields an empty sum mask and carry select on bit 0.
    always_comb begin
        sum_sel_nxt  = '0;
        cout_sel_nxt = '0;
        for (int unsigned i = 0; i < P_DATA_WIDTH; i++) begin
            sum_sel_nxt[i] = (i < 32'(eff_w));
        end
        for (int unsigned i = 0; i <= P_DATA_WIDTH; i++) begin
            cout_sel_nxt[i] = (i == 32'(eff_w));
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_take)      state_nxt = ST_FLUSH;
                else if (cfg_bad)  state_nxt = ST_IDLE;
                else if (i_run_en) state_nxt = ST_WARMUP;
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = i_run_en ? ST_WARMUP : ST_IDLE;
            end
            ST_WARMUP: begin
                if (warm_cnt_q == WARM_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_take)       state_nxt = ST_FLUSH;
                else if (cfg_bad)   state_nxt = ST_RUN;
                else if (!i_run_en) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters only advance while staying in their state, so every entry
    // (including FLUSH re-entry from RUN) starts from zero.
    always_comb begin
        flush_cnt_nxt = '0;
        warm_cnt_nxt  = '0;
        if (state_q == ST_FLUSH && state_nxt == ST_FLUSH) begin
            flush_cnt_nxt = flush_cnt_q + FLUSH_CW'(1);
        end
        if (state_q == ST_WARMUP && state_nxt == ST_WARMUP) begin
            warm_cnt_nxt = warm_cnt_q + WARM_CW'(1);
        end
    end

    // Moore outputs are registered from the next state so they change on
    // the same edge as the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            warm_cnt_q  <= '0;
            o_cfg_ready <= 1'b0;
            o_sum_sel   <= '1;
            o_cout_sel  <= COUT_RST;
            o_seed      <= '0;
            o_frac      <= '0;
            o_dp_rst_n  <= 1'b0;
            o_dp_en     <= 1'b0;
            o_out_valid <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            flush_cnt_q <= flush_cnt_nxt;
            warm_cnt_q  <= warm_cnt_nxt;
            o_cfg_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_RUN);
            o_dp_rst_n  <= (state_nxt != ST_FLUSH);
            o_dp_en     <= (state_nxt == ST_WARMUP) || (state_nxt == ST_RUN);
            o_out_valid <= (state_nxt == ST_RUN);
            if (cfg_take) begin
                o_sum_sel  <= sum_sel_nxt;
                o_cout_sel <= cout_sel_nxt;
                o_seed     <= i_cfg_seed;
                o_frac     <= i_cfg_frac;
            end
        end
    end

`ifdef DDSM_CFG_RANGE_CHECK_EN
    logic cfg_err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cfg_err_q <= 1'b0;
        else          cfg_err_q <= cfg_bad;
    end

    assign o_cfg_err = cfg_err_q;
`else
    assign o_cfg_err = 1'b0;
`endif

    assign o_state = state_q;

endmodule

// File: tb/tb_ddsm_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddsm_cfg_ctrl
//
// Directed self-checking bench for ddsm_cfg_ctrl (default parameters).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_ddsm_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_width;
    logic [7:0] cfg_seed;
    logic [7:0] cfg_frac;
    logic       run_en;
    logic [7:0] sum_sel;
    logic [8:0] cout_sel;
    logic [7:0] seed_q;
    logic [7:0] frac_q;
    logic       dp_rst_n;
    logic       dp_en;
    logic       out_valid;
    logic [2:0] state;
    logic       cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WARMUP = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    // {state, ready, sum, cout, seed, frac, dp_rst_n, dp_en, valid, err}
    localparam logic [40:0] RESET_VEC = {3'd0, 1'b0, 8'hFF, 9'h100, 8'h00, 8'h00, 4'b0000};

    always #5 clk = ~clk;

    ddsm_cfg_ctrl #(
        .P_DATA_WIDTH   (8),
        .P_STAGES       (3),
        .P_FLUSH_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_width (cfg_width),
        .i_cfg_seed  (cfg_seed),
        .i_cfg_frac  (cfg_frac),
        .i_run_en    (run_en),
        .o_sum_sel   (sum_sel),
        .o_cout_sel  (cout_sel),
        .o_seed      (seed_q),
        .o_frac      (frac_q),
        .o_dp_rst_n  (dp_rst_n),
        .o_dp_en     (dp_en),
        .o_out_valid (out_valid),
        .o_state     (state),
        .o_cfg_err   (cfg_err)
    );

    function automatic logic [40:0] out_vec();
        return {state, cfg_ready, sum_sel, cout_sel, seed_q, frac_q,
                dp_rst_n, dp_en, out_valid, cfg_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cycles, output bit ok);
        ok = (state === s);
        for (int i = 0; i < max_cycles && !ok; i++) begin
            step();
            ok = (state === s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; run_en = 1'b0;
        cfg_width = 4'd0; cfg_seed = 8'h00; cfg_frac = 8'h00;
        step(); step();
        n_checks++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({cfg_ready, dp_rst_n, state} !== {1'b1, 1'b1, S_IDLE}) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b dp_rst_n=%b state=%0d expected 1 1 0",
                     cfg_ready, dp_rst_n, state);
        end
    endtask

    task automatic test_basic();
        int first_hi = 0;
        int first_valid = 0;
        cfg_width = 4'd5; cfg_seed = 8'h11; cfg_frac = 8'h40;
        run_en = 1'b1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if ({sum_sel, cout_sel, seed_q, frac_q} !== {8'h1F, 9'h020, 8'h11, 8'h40}) begin
            n_fail++;
            $display("FAIL basic_latch: got sum=%h cout=%h seed=%h frac=%h expected 1f 020 11 40",
                     sum_sel, cout_sel, seed_q, frac_q);
        end
        n_checks++;
        if ({state, dp_rst_n, dp_en, cfg_ready} !== {S_FLUSH, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_flush_entry: got state=%0d dp_rst_n=%b dp_en=%b ready=%b expected 1 0 0 0",
                     state, dp_rst_n, dp_en, cfg_ready);
        end
        for (int edge_n = 1; edge_n <= 20; edge_n++) begin
            step();
            if (first_hi == 0 && dp_rst_n === 1'b1) first_hi = edge_n;
            if (edge_n == 9) begin
                n_checks++;
                if ({state, dp_en, out_valid} !== {S_WARMUP, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL basic_warmup: got state=%0d dp_en=%b valid=%b expected 3 1 0",
                             state, dp_en, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                first_valid = edge_n;
                break;
            end
        end
        n_checks++;
        if (first_hi != 8) begin
            n_fail++;
            $display("FAIL basic_flush_len: got %0d cycles expected 8", first_hi);
        end
        n_checks++;
        if (first_valid != 13 || state !== S_RUN) begin
            n_fail++;
            $display("FAIL basic_valid_latency: got edge %0d state=%0d expected 13 4",
                     first_valid, state);
        end
    endtask

    task automatic test_flush_hold();
        int low = 1;
        bit ok;
        cfg_width = 4'd8; cfg_seed = 8'h22; cfg_frac = 8'h33;
        run_en = 1'b1; cfg_valid = 1'b1;
        step();
        n_checks++;
        if ({out_valid, state, sum_sel, cout_sel, seed_q} !== {1'b0, S_FLUSH, 8'hFF, 9'h100, 8'h22}) begin
            n_fail++;
            $display("FAIL reconfig_run: got valid=%b state=%0d sum=%h cout=%h seed=%h expected 0 1 ff 100 22",
                     out_valid, state, sum_sel, cout_sel, seed_q);
        end
        cfg_width = 4'd0; cfg_seed = 8'h99; cfg_frac = 8'h55;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dp_rst_n === 1'b1) break;
            low++;
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (low != 8) begin
            n_fail++;
            $display("FAIL flush_hold_len: got %0d cycles expected 8", low);
        end
        n_checks++;
        if ({state, seed_q, frac_q, sum_sel} !== {S_LOAD, 8'h22, 8'h33, 8'hFF}) begin
            n_fail++;
            $display("FAIL flush_hold_capture: got state=%0d seed=%h frac=%h sum=%h expected 2 22 33 ff",
                     state, seed_q, frac_q, sum_sel);
        end
        wait_state(S_RUN, 10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_hold_to_run: got state=%0d expected 4", state);
        end
    endtask

    task automatic test_bypass();
        bit ok;
        cfg_width = 4'd0; cfg_seed = 8'hAA; cfg_frac = 8'h01;
        cfg_valid = 1'b1; run_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if ({state, sum_sel, cout_sel, seed_q} !== {S_FLUSH, 8'h00, 9'h001, 8'hAA}) begin
            n_fail++;
            $display("FAIL bypass_latch: got state=%0d sum=%h cout=%h seed=%h expected 1 00 001 aa",
                     state, sum_sel, cout_sel, seed_q);
        end
        wait_state(S_IDLE, 15, ok);
        n_checks++;
        if (!ok || {cfg_ready, dp_en, out_valid, sum_sel} !== {3'b100, 8'h00}) begin
            n_fail++;
            $display("FAIL bypass_to_idle: got state=%0d ready=%b en=%b valid=%b sum=%h expected 0 1 0 0 00",
                     state, cfg_ready, dp_en, out_valid, sum_sel);
        end
    endtask

    task automatic test_idle_run();
        run_en = 1'b1;
        step();
        n_checks++;
        if ({state, dp_en, dp_rst_n, out_valid} !== {S_WARMUP, 3'b110}) begin
            n_fail++;
            $display("FAIL idle_run_entry: got state=%0d en=%b dp_rst_n=%b valid=%b expected 3 1 1 0",
                     state, dp_en, dp_rst_n, out_valid);
        end
        step(); step(); step();
        n_checks++;
        if ({state, out_valid} !== {S_WARMUP, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_run_warmup_end: got state=%0d valid=%b expected 3 0", state, out_valid);
        end
        step();
        n_checks++;
        if ({state, out_valid} !== {S_RUN, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_run_enter_run: got state=%0d valid=%b expected 4 1", state, out_valid);
        end
        run_en = 1'b0;
        step();
        n_checks++;
        if ({state, dp_en, out_valid, cfg_ready, sum_sel, cout_sel} !== {S_IDLE, 3'b001, 8'h00, 9'h001}) begin
            n_fail++;
            $display("FAIL run_stop: got state=%0d en=%b valid=%b ready=%b sum=%h cout=%h expected 0 0 0 1 00 001",
                     state, dp_en, out_valid, cfg_ready, sum_sel, cout_sel);
        end
    endtask

    task automatic test_reset_warmup();
        run_en = 1'b1;
        step();
        step();
        rst_n = 1'b0; run_en = 1'b0;
        step();
        n_checks++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_in_warmup: got %h expected %h", out_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({state, cfg_ready} !== {S_IDLE, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_warmup_release: got state=%0d ready=%b expected 0 1", state, cfg_ready);
        end
    endtask

    task automatic test_width_over();
        bit ok;
        cfg_width = 4'd3; cfg_seed = 8'h33; cfg_frac = 8'h44;
        cfg_valid = 1'b1; run_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        wait_state(S_IDLE, 15, ok);
        n_checks++;
        if (!ok || {sum_sel, cout_sel} !== {8'h07, 9'h008}) begin
            n_fail++;
            $display("FAIL width3_setup: got state=%0d sum=%h cout=%h expected 0 07 008",
                     state, sum_sel, cout_sel);
        end
        cfg_width = 4'd12; cfg_seed = 8'h77; cfg_frac = 8'h88;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
`ifdef DDSM_CFG_RANGE_CHECK_EN
        n_checks++;
        if ({cfg_err, state, sum_sel, cout_sel, seed_q} !== {1'b1, S_IDLE, 8'h07, 9'h008, 8'h33}) begin
            n_fail++;
            $display("FAIL width12_reject: got err=%b state=%0d sum=%h cout=%h seed=%h expected 1 0 07 008 33",
                     cfg_err, state, sum_sel, cout_sel, seed_q);
        end
        step();
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL width12_err_pulse: got err=%b expected 0", cfg_err);
        end
`else
        n_checks++;
        if ({cfg_err, state, sum_sel, cout_sel, seed_q} !== {1'b0, S_FLUSH, 8'hFF, 9'h100, 8'h77}) begin
            n_fail++;
            $display("FAIL width12_clamp: got err=%b state=%0d sum=%h cout=%h seed=%h expected 0 1 ff 100 77",
                     cfg_err, state, sum_sel, cout_sel, seed_q);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_hold();
        test_bypass();
        test_idle_run();
        test_reset_warmup();
        test_width_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddsm_cfg_ctrl.md
DDSM_CFG_CTRL -- requirements
Module: ddsm_cfg_ctrl

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 8: EFM accumulator width; all data and mask ports are this width.
REQ-002 SHALL have parameter P_STAGES, default 3: number of cascaded EFM stages, which sets the pipeline depth.
REQ-003 SHALL have parameter P_FLUSH_CYCLES, default 8: number of cycles the datapath is held in reset.
REQ-004 SHALL have port i_clk, input, 1: the single clock.
REQ-005 SHALL have port i_rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port i_cfg_valid, input, 1: configuration request.
REQ-007 SHALL have port o_cfg_ready, output, 1: controller can accept a configuration.
REQ-008 SHALL have port i_cfg_width, input, 4: requested effective EFM width, legal range 0..8.
REQ-009 SHALL have port i_cfg_seed, input, 8: accumulator seed.
REQ-010 SHALL have port i_cfg_frac, input, 8: fractional input word.
REQ-011 SHALL have port i_run_en, input, 1: run request.
REQ-012 SHALL have port o_sum_sel, output, 8: sum mask broadcast to all stages.
REQ-013 SHALL have port o_cout_sel, output, 9: one-hot carry-select broadcast to all stages.
REQ-014 SHALL have ports o_seed and o_frac, output, 8 each: the latched seed and fractional word.
REQ-015 SHALL have port o_dp_rst_n, output, 1: datapath reset, active-low.
REQ-016 SHALL have port o_dp_en, output, 1: datapath clock-enable.
REQ-017 SHALL have port o_out_valid, output, 1: modulator output is valid.
REQ-018 SHALL have port o_state, output, 3: current state encoding.
REQ-019 SHALL have port o_cfg_err, output, 1: one-cycle pulse on a rejected configuration.

Function
REQ-020 SHALL implement states IDLE=0, FLUSH=1, LOAD=2, WARMUP=3, RUN=4.
REQ-021 o_cfg_ready SHALL be 1 in IDLE and RUN only; a configuration is accepted on any edge where i_cfg_valid and o_cfg_ready are both 1.
REQ-022 On acceptance, SHALL latch width, seed and frac; all selection and data outputs update on that same edge; next state is FLUSH.
REQ-023 Width mapping for w in 1..8: o_sum_sel = 2^w - 1 and o_cout_sel = 1 << w.
REQ-024 Width mapping for w = 0 (bypass): o_sum_sel = 0x00 and o_cout_sel = 0x001.
REQ-025 In FLUSH, o_dp_rst_n SHALL be 0 and o_dp_en 0 for exactly P_FLUSH_CYCLES cycles; the state then goes to LOAD.
REQ-026 LOAD SHALL last 1 cycle with o_dp_rst_n=1 and o_dp_en=0; next state is WARMUP if i_run_en=1, otherwise IDLE.
REQ-027 WARMUP SHALL assert o_dp_en=1 for P_STAGES+1 cycles, then go to RUN; o_out_valid stays 0 throughout WARMUP.
REQ-028 RUN SHALL drive o_dp_en=1 and o_out_valid=1.
REQ-029 In RUN, i_run_en=0 SHALL move the state to IDLE on the next edge, clearing o_dp_en and o_out_valid while keeping the configuration.
REQ-030 In IDLE, i_run_en=1 with no accepted configuration SHALL go to WARMUP.
REQ-031 In IDLE or RUN, if a configuration is accepted and i_run_en changes on the same edge, the configuration wins: next state is FLUSH.
REQ-032 i_cfg_valid in FLUSH, LOAD or WARMUP SHALL be ignored; no error is raised and nothing is latched.
REQ-033 Flush and warmup counters SHALL restart from zero on every state entry.

Reset
REQ-034 While i_rst_n=0 at a clock edge, the block SHALL apply: state=IDLE, o_cfg_ready=0, o_sum_sel=0xFF, o_cout_sel=0x100, o_seed=0, o_frac=0, o_dp_rst_n=0, o_dp_en=0, o_out_valid=0, o_cfg_err=0, counters=0.
REQ-035 Reset SHALL take priority over all other inputs, including in mid-FLUSH or mid-WARMUP.
REQ-036 On the first edge after reset release, o_cfg_ready=1 and o_dp_rst_n=1.

Configuration
REQ-037 The macro DDSM_CFG_RANGE_CHECK_EN controls width range checking.
REQ-038 With DDSM_CFG_RANGE_CHECK_EN defined, an accepted request with i_cfg_width>8 SHALL be rejected: o_cfg_err=1 for one cycle, no registers change, and the state is unchanged.
REQ-039 Without DDSM_CFG_RANGE_CHECK_EN, i_cfg_width>8 SHALL be clamped to 8, and o_cfg_err SHALL be tied to 0.

Verification
REQ-040 Release reset, accept width=5, seed=0x11, frac=0x40, i_run_en=1 -> o_sum_sel=0x1F, o_cout_sel=0x020, o_dp_rst_n low 8 cycles, o_out_valid rises 13 edges after the accepting edge.
REQ-041 Accept width=0 -> o_sum_sel=0x00, o_cout_sel=0x001.
REQ-042 In RUN, accept width=8 -> o_out_valid drops the next cycle, FLUSH is re-entered, and o_cout_sel=0x100.
REQ-043 Assert i_rst_n=0 during WARMUP cycle 2 -> all outputs reach their reset values (REQ-034) on that edge, and state=IDLE after release.
REQ-044 Width=12 with the macro defined -> one-cycle o_cfg_err, outputs unchanged; without the macro -> o_sum_sel=0xFF, o_cout_sel=0x100.
REQ-045 Drive i_cfg_valid=1 continuously during FLUSH -> no second capture, and exactly 8 flush cycles.
